// File: rtl/mem_interface_pkg.sv
// Request classification shared by the memory interface and its RAM wrapper.
// Stall and reset both collapse to a hold so the datapath has one gating point.
package mem_interface_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_READ,
        REQ_WRITE,
        REQ_HOLD
    } req_t;

    // Write beats read when both are asserted; stall/reset suppress everything.
    function automatic req_t decode_req(input logic reset, input logic stall,
                                        input logic rd, input logic wr);
        if (reset || stall) return REQ_HOLD;
        if (wr)             return REQ_WRITE;
        if (rd)             return REQ_READ;
        return REQ_IDLE;
    endfunction

endpackage

// File: rtl/mem_bram.sv
// Single-port synchronous RAM with registered, write-first read port.
// Contents are intentionally not reset.
module mem_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 9
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_interface.sv
// Word-addressed single-port memory front end: one request per cycle,
// read data one cycle later with its address, outputs frozen under stall.
module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_BITS   = 6,
    parameter int OFFSET_BITS  = 3,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDRESS_BITS-1:0] address,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic [ADDRESS_BITS-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    valid,
    output logic                    ready,
    input  logic                    report,
    input  logic                    m_stall
);

    localparam int DEPTH_BITS = INDEX_BITS + OFFSET_BITS;

    req_t                  req;
    logic [DEPTH_BITS-1:0] ram_addr;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] held_data;
    logic                  cycle_phase;
    logic [31:0]           cycles;

    assign req      = decode_req(reset, m_stall, read, write);
    // Line/word split; upper address bits alias.
    assign ram_addr = {address[DEPTH_BITS-1:OFFSET_BITS], address[OFFSET_BITS-1:0]};
    assign ram_we   = (req == REQ_WRITE);

    mem_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (DEPTH_BITS)
    ) u_bram (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (in_data),
        .rdata (ram_rdata)
    );

    // The RAM output register moves on every edge, so the last completed
    // read is captured here and presented whenever valid drops.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_addr    <= '0;
            valid       <= 1'b0;
            held_data   <= '0;
            cycle_phase <= 1'b0;
            cycles      <= '0;
        end else begin
            valid       <= (req == REQ_READ);
            if (req == REQ_READ) out_addr <= address;
            if (valid)           held_data <= ram_rdata;
            cycle_phase <= ~cycle_phase;
            if (cycle_phase)     cycles <= cycles + 32'd1;
        end
    end

    assign out_data = valid ? ram_rdata : held_data;
    assign ready    = ~m_stall;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (report) begin
            $display("mem_interface core=%0d cycle=%0d read=%b write=%b address=%h in_data=%h out_addr=%h out_data=%h valid=%b ready=%b m_stall=%b",
                     CORE, cycles, read, write, address, in_data, out_addr, out_data,
                     valid, ready, m_stall);
        end
    end
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface: reference memory model plus a
// queue of expected read responses popped whenever valid is seen.
module tb_mem_interface;

    localparam int DW = 32;
    localparam int AW = 20;
    localparam int DEPTH = 512;

    logic          clock = 1'b0;
    logic          reset, read, write, report, m_stall;
    logic [AW-1:0] address, out_addr;
    logic [DW-1:0] in_data, out_data;
    logic          valid, ready;

    mem_interface #(
        .CORE(0), .DATA_WIDTH(DW), .INDEX_BITS(6), .OFFSET_BITS(3), .ADDRESS_BITS(AW)
    ) dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .in_data(in_data), .out_addr(out_addr),
        .out_data(out_data), .valid(valid), .ready(ready),
        .report(report), .m_stall(m_stall)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] model_mem [DEPTH];
    logic [AW+DW-1:0] exp_q [$];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus followed by checks against the model.
    task automatic cyc(input string tag, input logic rst, input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic st);
        logic [AW+DW-1:0] e;
        logic exp_valid;
        reset = rst; read = rd; write = wr; address = a; in_data = d; m_stall = st;
        #1;
        chk({tag, ".ready"}, 64'(ready), 64'(!st));
        exp_valid = !rst && !st && rd && !wr;
        if (exp_valid) exp_q.push_back({a, model_mem[a % DEPTH]});
        @(posedge clock);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_addr = '0;
            exp_data = '0;
        end else if (!st && wr) begin
            model_mem[a % DEPTH] = d;
        end
        chk({tag, ".valid"}, 64'(valid), 64'(exp_valid));
        if (valid) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".unexpected_read"}, 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                exp_addr = e[AW+DW-1:DW];
                exp_data = e[DW-1:0];
            end
        end
        chk({tag, ".out_addr"}, 64'(out_addr), 64'(exp_addr));
        chk({tag, ".out_data"}, 64'(out_data), 64'(exp_data));
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_addr = '0; exp_data = '0;
        reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; in_data = '0;
        m_stall = 1'b0; report = 1'b0;
        @(posedge clock); #1;

        // Reset held with a pending read request
        cyc("rst0", 1, 1, 0, 20'h4, 0, 0);
        cyc("rst1", 1, 1, 0, 20'h4, 0, 0);
        chk("rst.out_data_zero", 64'(out_data), 64'(0));

        // Writes then back-to-back reads
        cyc("wr4", 0, 0, 1, 20'h4, 32'h0000_0013, 0);
        cyc("wr5", 0, 0, 1, 20'h5, 32'hDEAD_BEEF, 0);
        cyc("rd4", 0, 1, 0, 20'h4, 0, 0);
        chk("rd4.data_const", 64'(out_data), 64'h13);
        cyc("rd5", 0, 1, 0, 20'h5, 0, 0);
        chk("rd5.data_const", 64'(out_data), 64'hDEAD_BEEF);
        cyc("idle", 0, 0, 0, 20'h0, 0, 0);

        // Streaming reads interrupted by a 3-cycle stall
        cyc("srd4", 0, 1, 0, 20'h4, 0, 0);
        cyc("srd5", 0, 1, 0, 20'h5, 0, 0);
        for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, 20'h4, 32'h1234, 1);
        chk("stall.frozen_addr", 64'(out_addr), 64'h5);
        cyc("post_stall", 0, 1, 0, 20'h4, 0, 0);
        chk("post_stall.data_const", 64'(out_data), 64'h13);

        // Stalled write must not reach storage
        cyc("stall_wr", 0, 0, 1, 20'h4, 32'hFFFF_FFFF, 1);
        cyc("rd4_again", 0, 1, 0, 20'h4, 0, 0);

        // Read/write collision then read-after-write
        cyc("coll", 0, 1, 1, 20'h7, 32'h55, 0);
        cyc("raw7", 0, 1, 0, 20'h7, 0, 0);
        chk("raw7.data_const", 64'(out_data), 64'h55);

        // Aliasing modulo depth
        cyc("wr200", 0, 0, 1, 20'h200, 32'hAA, 0);
        cyc("rd0", 0, 1, 0, 20'h0, 0, 0);
        chk("alias.data_const", 64'(out_data), 64'hAA);

        // Varied pattern across lines
        for (int i = 0; i < 8; i++) cyc("pw", 0, 0, 1, AW'(i * 9 + 64), $urandom, 0);
        for (int i = 0; i < 8; i++) cyc("pr", 0, 1, 0, AW'(i * 9 + 64), 0, 0);

        // Reset mid-read; storage survives
        cyc("rd5b", 0, 1, 0, 20'h5, 0, 0);
        report = 1'b1;
        cyc("midrst", 1, 1, 0, 20'h4, 0, 0);
        report = 1'b0;
        chk("midrst.data_zero", 64'(out_data), 64'(0));
        cyc("rd4_after_rst", 0, 1, 0, 20'h4, 0, 0);
        chk("rd4_after_rst.data_const", 64'(out_data), 64'h13);
        cyc("drain", 0, 0, 0, 20'h0, 0, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
